// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main FSM for the multicycle MIPS-subset datapath.
// Define MULTICYCLE_BNE_EN to add BNE (opcode 000101) through a BNEEX state.
module multicycle_main_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam logic [STATE_W-1:0] IDLE   = STATE_W'(0);
    localparam logic [STATE_W-1:0] FETCH  = STATE_W'(1);
    localparam logic [STATE_W-1:0] DECODE = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMADR = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMRD  = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWB  = STATE_W'(5);
    localparam logic [STATE_W-1:0] MEMWR  = STATE_W'(6);
    localparam logic [STATE_W-1:0] REXEC  = STATE_W'(7);
    localparam logic [STATE_W-1:0] RWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] BEQEX  = STATE_W'(9);
    localparam logic [STATE_W-1:0] ADDIEX = STATE_W'(10);
    localparam logic [STATE_W-1:0] ADDIWB = STATE_W'(11);
    localparam logic [STATE_W-1:0] JEX    = STATE_W'(12);
    localparam logic [STATE_W-1:0] BNEEX  = STATE_W'(13);

    logic [STATE_W-1:0] state, state_next, decode_next;
    logic illegal;
    logic in_fetch, in_decode, in_memadr, in_memrd, in_memwb, in_memwr;
    logic in_rexec, in_rwb, in_beqex, in_addiex, in_addiwb, in_jex, in_bneex;
    logic pc_write, branch, taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        decode_next = FETCH;
        illegal = 1'b0;
        case (op)
            OP_LW, OP_SW: decode_next = MEMADR;
            OP_R:         decode_next = REXEC;
            OP_BEQ:       decode_next = BEQEX;
            OP_ADDI:      decode_next = ADDIEX;
            OP_J:         decode_next = JEX;
`ifdef MULTICYCLE_BNE_EN
            OP_BNE:       decode_next = BNEEX;
`endif
            default:      illegal = 1'b1;
        endcase
    end

    // Unreachable encodings fall to the default arm and recover into FETCH.
    always_comb begin
        state_next = FETCH;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   state_next = mem_ready ? DECODE : FETCH;
            DECODE:  state_next = decode_next;
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_next = FETCH;
            MEMWR:   state_next = mem_ready ? FETCH : MEMWR;
            REXEC:   state_next = RWB;
            RWB:     state_next = FETCH;
            BEQEX:   state_next = FETCH;
            ADDIEX:  state_next = ADDIWB;
            ADDIWB:  state_next = FETCH;
            JEX:     state_next = FETCH;
`ifdef MULTICYCLE_BNE_EN
            BNEEX:   state_next = FETCH;
`endif
            default: state_next = FETCH;
        endcase
    end

    assign in_fetch  = state == FETCH;
    assign in_decode = state == DECODE;
    assign in_memadr = state == MEMADR;
    assign in_memrd  = state == MEMRD;
    assign in_memwb  = state == MEMWB;
    assign in_memwr  = state == MEMWR;
    assign in_rexec  = state == REXEC;
    assign in_rwb    = state == RWB;
    assign in_beqex  = state == BEQEX;
    assign in_addiex = state == ADDIEX;
    assign in_addiwb = state == ADDIWB;
    assign in_jex    = state == JEX;
`ifdef MULTICYCLE_BNE_EN
    assign in_bneex  = state == BNEEX;
`else
    assign in_bneex  = 1'b0;
`endif

    assign branch     = in_beqex | in_bneex;
    assign taken      = (in_beqex & zero) | (in_bneex & ~zero);
    assign pc_write   = (in_fetch & mem_ready) | in_jex;
    assign pc_en      = pc_write | taken;
    assign mem_req    = in_fetch | in_memrd | in_memwr;
    assign mem_write  = in_memwr;
    assign iord       = in_memrd | in_memwr;
    assign ir_write   = in_fetch & mem_ready;
    assign reg_write  = in_memwb | in_rwb | in_addiwb;
    assign reg_dst    = in_rwb;
    assign mem_to_reg = in_memwb;
    assign alu_src_a  = in_memadr | in_rexec | branch | in_addiex;
    assign alu_src_b  = in_fetch ? 2'b01 : in_decode ? 2'b11 : (in_memadr | in_addiex) ? 2'b10 : 2'b00;
    assign alu_op     = in_rexec ? 2'b10 : branch ? 2'b01 : 2'b00;
    assign pc_src     = in_jex ? 2'b10 : branch ? 2'b01 : 2'b00;
    assign illegal_op = in_decode & illegal;
    assign state_o    = state;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: directed checks of the multicycle control FSM.
module tb_multicycle_main_control;
    logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = 6'b0;
    logic mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_o;
    int errors = 0, checks = 0;

    localparam logic [3:0] S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4, S_MEMWB = 5;
    localparam logic [3:0] S_MEMWR = 6, S_REXEC = 7, S_RWB = 8, S_BEQEX = 9, S_ADDIEX = 10, S_ADDIWB = 11;
    localparam logic [3:0] S_JEX = 12, S_BNEEX = 13;

    localparam logic [15:0] MREQ = 16'h8000, MWR = 16'h4000, IORD = 16'h2000, IRW = 16'h1000;
    localparam logic [15:0] RW = 16'h0800, RDST = 16'h0400, M2R = 16'h0200, SA = 16'h0100;
    localparam logic [15:0] SB1 = 16'h0040, SB2 = 16'h0080, SB3 = 16'h00C0, OP1 = 16'h0010, OP2 = 16'h0020;
    localparam logic [15:0] PS1 = 16'h0004, PS2 = 16'h0008, PCEN = 16'h0002, ILL = 16'h0001;
    localparam logic [15:0] C_FETCH = MREQ | IRW | SB1 | PCEN, C_FSTALL = MREQ | SB1;

    multicycle_main_control #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_en(pc_en), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ctl();
        return {mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, alu_op, pc_src, pc_en, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [3:0] st, input logic [15:0] c);
        checks += 2;
        assert (state_o === st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state_o, st);
        end
        assert (ctl() === c) else begin
            errors++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, ctl(), c);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] c);
        @(negedge clk);
        chk(tag, st, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_hold", S_IDLE, 16'h0);
        rst_n = 1'b1;
        cyc("reset_release", S_IDLE, 16'h0);
        mem_ready = 1'b1;
        op = 6'b100011;
        cyc("lw_fetch", S_FETCH, C_FETCH);
        cyc("lw_decode", S_DECODE, SB3);
        cyc("lw_memadr", S_MEMADR, SA | SB2);
        cyc("lw_memrd", S_MEMRD, MREQ | IORD);
        cyc("lw_memwb", S_MEMWB, RW | M2R);
        op = 6'b000000;
        cyc("r_fetch", S_FETCH, C_FETCH);
        cyc("r_decode", S_DECODE, SB3);
        cyc("r_exec", S_REXEC, SA | OP2);
        cyc("r_wb", S_RWB, RW | RDST);
        op = 6'b000100;
        zero = 1'b1;
        cyc("beq_t_fetch", S_FETCH, C_FETCH);
        cyc("beq_t_decode", S_DECODE, SB3);
        cyc("beq_taken", S_BEQEX, SA | OP1 | PS1 | PCEN);
        zero = 1'b0;
        cyc("beq_n_fetch", S_FETCH, C_FETCH);
        cyc("beq_n_decode", S_DECODE, SB3);
        cyc("beq_not_taken", S_BEQEX, SA | OP1 | PS1);
        op = 6'b101011;
        cyc("sw_fetch", S_FETCH, C_FETCH);
        cyc("sw_decode", S_DECODE, SB3);
        cyc("sw_memadr", S_MEMADR, SA | SB2);
        mem_ready = 1'b0;
        cyc("sw_memwr_wait", S_MEMWR, MREQ | MWR | IORD);
        mem_ready = 1'b1;
        cyc("sw_memwr_done", S_MEMWR, MREQ | MWR | IORD);
        op = 6'b001000;
        cyc("addi_fetch", S_FETCH, C_FETCH);
        cyc("addi_decode", S_DECODE, SB3);
        cyc("addi_exec", S_ADDIEX, SA | SB2);
        cyc("addi_wb", S_ADDIWB, RW);
        op = 6'b000010;
        cyc("j_fetch", S_FETCH, C_FETCH);
        cyc("j_decode", S_DECODE, SB3);
        cyc("j_exec", S_JEX, PS2 | PCEN);
        op = 6'b111111;
        cyc("ill_fetch", S_FETCH, C_FETCH);
        cyc("ill_decode", S_DECODE, SB3 | ILL);
        op = 6'b000101;
        mem_ready = 1'b0;
        cyc("stall_1", S_FETCH, C_FSTALL);
        cyc("stall_2", S_FETCH, C_FSTALL);
        cyc("stall_3", S_FETCH, C_FSTALL);
        mem_ready = 1'b1;
        cyc("stall_go", S_FETCH, C_FETCH);
`ifdef MULTICYCLE_BNE_EN
        cyc("bne_decode", S_DECODE, SB3);
        cyc("bne_taken", S_BNEEX, SA | OP1 | PS1 | PCEN);
`else
        cyc("bne_illegal", S_DECODE, SB3 | ILL);
`endif
        op = 6'b100011;
        cyc("abort_fetch", S_FETCH, C_FETCH);
        cyc("abort_decode", S_DECODE, SB3);
        cyc("abort_memadr", S_MEMADR, SA | SB2);
        mem_ready = 1'b0;
        cyc("abort_memrd", S_MEMRD, MREQ | IORD);
        rst_n = 1'b0;
        #1;
        chk("abort_async", S_IDLE, 16'h0);
        mem_ready = 1'b1;
        cyc("abort_held", S_IDLE, 16'h0);
        rst_n = 1'b1;
        cyc("abort_release", S_IDLE, 16'h0);
        cyc("abort_refetch", S_FETCH, C_FETCH);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS-subset datapath: sequences fetch, decode, execute, memory and writeback per instruction.
- Drives all datapath mux selects and write enables, plus the 2-bit ALU operation class to the ALU-control decoder, which resolves funct into the 3-bit ALU control line.
- Stalls on memory access until the memory reports ready.

Parameters:
- STATE_W, 4, width of state register; must be ≥4.

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction opcode from IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a write
- iord  out  1  address mux: 0=PC, 1=ALUOut
- ir_write  out  1  load instruction register
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
- alu_src_a  out  1  ALU A: 0=PC, 1=reg A
- alu_src_b  out  2  ALU B: 00=reg B, 01=const 4, 10=signext imm, 11=signext imm<<2
- alu_op  out  2  to ALU control: 00=add, 01=sub, 10=use funct
- pc_src  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- pc_en  out  1  PC write enable
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state_o  out  STATE_W  current state, debug

Behaviour:
- Outputs are Moore decodes of the state register, except pc_en = pc_write | (branch & zero) and the mem_ready-gated enables below. Unlisted outputs are 0 in every state.
- Reset (asynchronous, rst_n=0): state = IDLE; all outputs 0. IDLE → FETCH unconditionally on the next edge after release.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; → DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - LW/SW → MEMADR; R → REXEC; BEQ → BEQEX; ADDI → ADDIEX; J → JEX.
  - Any other opcode → FETCH with illegal_op=1 this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW → MEMRD; SW → MEMWR. op is held stable by the IR.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready, then → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. → FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Waits for mem_ready, then → FETCH.
- REXEC: alu_src_a=1, alu_src_b=00, alu_op=10. → RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. → FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. pc_en=zero. → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. → FETCH.
- JEX: pc_src=10, pc_write=1. → FETCH.
- Latency with mem_ready tied high:
  - R / ADDI / SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ / J: 3 cycles.
  - Each low mem_ready cycle adds exactly one cycle.
- Unreachable state encodings → FETCH on the next edge, outputs 0 meanwhile.
- Reset asserted mid-instruction aborts immediately; no pending write completes.
- pc_en and reg_write are never both 1 in the same cycle except via the FETCH pc_write path (reg_write=0 there).

Optional Feature:
- Macro MULTICYCLE_BNE_EN.
- Defined: opcode 000101 (BNE) decodes in DECODE → BNEEX, which drives the same outputs as BEQEX but pc_en = ~zero. Latency 3 cycles.
- Undefined: 000101 is illegal (illegal_op pulse, → FETCH); no BNEEX state exists.

Test Plan:
- rst_n=0 mid-MEMRD → all outputs 0 immediately; after release, IDLE then FETCH with mem_req=1 on the second edge.
- mem_ready=1, op=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_to_reg=1 on cycle 5 only.
- op=000000 → REXEC alu_op=10, alu_src_b=00; RWB reg_dst=1, reg_write=1; 4 cycles total.
- op=000100 with zero=1 → pc_en=1, pc_src=01 in BEQEX; repeat with zero=0 → pc_en=0 in BEQEX.
- FETCH with mem_ready=0 for 3 cycles, then 1 → ir_write/pc_en low for 3 cycles, high exactly once, then DECODE.
- op=000101 → without macro: illegal_op=1 for one cycle, next state FETCH; with macro and zero=0: pc_en=1 in BNEEX.
